// File: rtl/hazard_controller_pkg.sv
// Shared decode definitions for the decode-stage issue controller.
// Provides opcode constants, instruction type and issue FSM state types.
package hazard_controller_pkg;

    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [2:0] {
        IT_R,
        IT_I,
        IT_S,
        IT_B,
        IT_U,
        IT_J,
        IT_NONE
    } instr_type_t;

    typedef enum logic {
        RUN,
        FLUSH
    } hz_state_t;

    function automatic instr_type_t classify(input logic [6:0] op);
        instr_type_t t;
        case (op)
            OP_REG:    t = IT_R;
            OP_IMM:    t = IT_I;
            OP_LOAD:   t = IT_I;
            OP_JALR:   t = IT_I;
            OP_SYSTEM: t = IT_I;
            OP_STORE:  t = IT_S;
            OP_BRANCH: t = IT_B;
            OP_LUI:    t = IT_U;
            OP_AUIPC:  t = IT_U;
            OP_JAL:    t = IT_J;
            default:   t = IT_NONE;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Register scoreboard: busy bit per architectural register plus writer count.
// Ports: set (issue), wb (retire), squash (redirect) inputs; busy/inflight
// outputs and the view used by the hazard check (wb-masked when
// HAZARD_WB_BYPASS_EN is defined, registered state otherwise).
module hazard_scoreboard (
    input  logic        clk,
    input  logic        rst,
    input  logic        set_en,
    input  logic [4:0]  set_rd,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        squash_en,
    input  logic [4:0]  squash_rd,
    output logic [31:0] busy_mask,
    output logic [4:0]  inflight,
    output logic [31:0] busy_view,
    output logic [4:0]  inflight_view
);

    logic [31:0] busy_q;
    logic [4:0]  inflight_q;
    logic        wb_hit;
    logic        sq_hit;
    logic [31:0] wb_mask;
    logic [31:0] sq_mask;
    logic [31:0] set_mask;

    // Only registers that are actually pending retire, so the count
    // always equals the number of set busy bits.
    assign wb_hit = wb_valid && (wb_rd != 5'd0) && busy_q[wb_rd];
    assign sq_hit = squash_en && (squash_rd != 5'd0) && busy_q[squash_rd]
                    && !(wb_hit && (wb_rd == squash_rd));

    assign wb_mask  = wb_hit ? (32'd1 << wb_rd) : 32'd0;
    assign sq_mask  = sq_hit ? (32'd1 << squash_rd) : 32'd0;
    assign set_mask = (set_en && set_rd != 5'd0) ? (32'd1 << set_rd) : 32'd0;

`ifdef HAZARD_WB_BYPASS_EN
    assign busy_view     = busy_q & ~wb_mask;
    assign inflight_view = inflight_q - 5'(wb_hit);
`else
    assign busy_view     = busy_q;
    assign inflight_view = inflight_q;
`endif

    assign busy_mask = busy_q;
    assign inflight  = inflight_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q     <= 32'd0;
            inflight_q <= 5'd0;
        end else begin
            busy_q     <= ((busy_q & ~wb_mask & ~sq_mask) | set_mask)
                          & 32'hFFFF_FFFE;
            inflight_q <= inflight_q + 5'(set_mask != 32'd0)
                          - 5'(wb_hit) - 5'(sq_hit);
        end
    end

endmodule

// File: rtl/hazard_controller.sv
// Decode-stage issue controller: RAW/WAW/window-full stalls and redirect flush.
// Ports: fetch (if_valid/if_instr/if_ready), decoder word (dec_instr),
// writeback (wb_valid/wb_rd), redirect, status (busy_mask/inflight/stall_cnt).
// Option: HAZARD_WB_BYPASS_EN lets a same-cycle writeback release a stall.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_INFLIGHT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [31:0] if_instr,
    output logic        if_ready,
    output logic [31:0] dec_instr,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic        redirect,
    output logic [31:0] busy_mask,
    output logic [4:0]  inflight,
    output logic [15:0] stall_cnt
);

    localparam logic [15:0] FLUSH_LOAD = 16'(FLUSH_CYCLES - 1);
    localparam logic [4:0]  MAX_W      = 5'(MAX_INFLIGHT);

    hz_state_t   state;
    logic [15:0] flush_cnt;
    logic        last_v;
    logic [4:0]  last_rd;

    logic [6:0]  op;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    instr_type_t it;
    logic        use_rs1;
    logic        use_rs2;
    logic        writer;
    logic        raw;
    logic        waw;
    logic        full;
    logic        hazard;
    logic        issue;
    logic [31:0] busy_view;
    logic [4:0]  inflight_view;

    assign op  = if_instr[6:0];
    assign rs1 = if_instr[19:15];
    assign rs2 = if_instr[24:20];
    assign rd  = if_instr[11:7];
    assign it  = classify(op);

    assign use_rs1 = (it == IT_R) || (it == IT_I) || (it == IT_S) || (it == IT_B);
    assign use_rs2 = (it == IT_R) || (it == IT_S) || (it == IT_B);
    assign writer  = ((it == IT_R) || (it == IT_I) || (it == IT_U) || (it == IT_J))
                     && (rd != 5'd0);

    assign raw  = (use_rs1 && rs1 != 5'd0 && busy_view[rs1])
               || (use_rs2 && rs2 != 5'd0 && busy_view[rs2]);
    assign waw  = writer && busy_view[rd];
    assign full = writer && (inflight_view == MAX_W);
    assign hazard = raw || waw || full;

    assign issue = !rst && (state == RUN) && !redirect && if_valid && !hazard;

    // Redirect and FLUSH cycles consume the fetch word so wrong-path
    // instructions are dropped rather than held.
    assign if_ready  = !rst && (redirect || (state == FLUSH) || issue);
    assign dec_instr = issue ? if_instr : 32'h0;

    hazard_scoreboard u_sb (
        .clk           (clk),
        .rst           (rst),
        .set_en        (issue && writer),
        .set_rd        (rd),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .squash_en     (redirect && last_v),
        .squash_rd     (last_rd),
        .busy_mask     (busy_mask),
        .inflight      (inflight),
        .busy_view     (busy_view),
        .inflight_view (inflight_view)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= 16'd0;
            last_v    <= 1'b0;
            last_rd   <= 5'd0;
            stall_cnt <= 16'd0;
        end else begin
            if (if_valid && !if_ready && stall_cnt != 16'hFFFF)
                stall_cnt <= stall_cnt + 16'd1;
            if (redirect) begin
                state     <= FLUSH;
                flush_cnt <= FLUSH_LOAD;
                last_v    <= 1'b0;
            end else begin
                case (state)
                    FLUSH: begin
                        if (flush_cnt == 16'd0)
                            state <= RUN;
                        else
                            flush_cnt <= flush_cnt - 16'd1;
                    end
                    default: begin
                        // last_rd tracks the word now at the decoder output,
                        // which a redirect next cycle must squash.
                        if (issue) begin
                            last_v  <= writer;
                            last_rd <= rd;
                        end else if (!if_valid) begin
                            last_v <= 1'b0;
                        end
                    end
                endcase
            end
        end
    end

endmodule
